// File: rtl/miriscv_hazard_unit.sv
// Purpose : RAW-hazard resolver for the D->E->M pipe: operand bypass selects plus stall/bubble control.
// Latency : bypass/stall/bubble outputs are combinational from shadow state and D inputs; shadows update on clk_i.
// Backpressure: M stalls on !m_ready_i, E stalls on !e_ready_i or an M stall, and D stalls on a hazard or an E stall.
//
// Ports:
//   clk_i, arstn_i                  clock, asynchronous active-low reset
//   d_*_i                           fields of the instruction currently in D
//   e_ready_i / m_ready_i           E result complete / M stage complete
//   flush_i                         redirect: discard the instruction in D this cycle
//   rs1_bypass_o / rs2_bypass_o     operand mux selects (0 none, 1 from E, 2 from M)
//   d_stall_o, e_stall_o, m_stall_o stage hold controls
//   e_bubble_o                      load a NOP into E this cycle
//   stall_cnt_o                     saturating count of cycles with a valid D held by a stall
module miriscv_hazard_unit #(
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk_i,
   input  logic                   arstn_i,
   input  logic                   d_valid_i,
   input  logic [4:0]             d_rs1_addr_i,
   input  logic [4:0]             d_rs2_addr_i,
   input  logic                   d_rs1_used_i,
   input  logic                   d_rs2_used_i,
   input  logic [4:0]             d_rd_addr_i,
   input  logic                   d_we_i,
   input  logic                   d_is_load_i,
   input  logic                   d_is_mdu_i,
   input  logic                   e_ready_i,
   input  logic                   m_ready_i,
   input  logic                   flush_i,
   output logic [1:0]             rs1_bypass_o,
   output logic [1:0]             rs2_bypass_o,
   output logic                   d_stall_o,
   output logic                   e_stall_o,
   output logic                   m_stall_o,
   output logic                   e_bubble_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   localparam logic [1:0] NO_BYPASS = 2'd0;
   localparam logic [1:0] BYPASS_E  = 2'd1;
   localparam logic [1:0] BYPASS_M  = 2'd2;

   // Shadow copies of the instructions occupying E and M
   logic                   r_e_valid;
   logic                   r_e_we;
   logic                   r_e_is_load;
   logic                   r_e_is_mdu;
   logic [4:0]             r_e_rd;
   logic                   r_m_valid;
   logic                   r_m_we;
   logic                   r_m_is_load;
   logic [4:0]             r_m_rd;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic       w_m_stall;
   logic       w_e_stall;
   logic       w_e_fwd_ok;
   logic       w_m_fwd_ok;
   logic [2:0] w_rs1_res;
   logic [2:0] w_rs2_res;
   logic       w_hazard;
   logic       w_d_stall;
   logic       w_issue;

   // x0 is never a real dependency, so it can neither forward nor stall
   function automatic logic f_hit(input logic       used,
                                  input logic [4:0] rs,
                                  input logic       vld,
                                  input logic       we,
                                  input logic [4:0] rd);
      return used & vld & we & (rd == rs) & (rs != 5'd0);
   endfunction

   // Returns {hazard, select}; the youngest producer (E) shadows an older one in M
   function automatic logic [2:0] f_resolve(input logic hit_e,
                                            input logic hit_m,
                                            input logic e_ok,
                                            input logic m_ok);
      if (hit_e)
         return e_ok ? {1'b0, BYPASS_E} : {1'b1, NO_BYPASS};
      else if (hit_m)
         return m_ok ? {1'b0, BYPASS_M} : {1'b1, NO_BYPASS};
      else
         return {1'b0, NO_BYPASS};
   endfunction

   always_comb begin
      w_m_stall  = r_m_valid & ~m_ready_i;
      w_e_stall  = r_e_valid & (~e_ready_i | w_m_stall);
      // A load's data only exists at the end of M; an MDU result only once E reports ready
      w_e_fwd_ok = ~r_e_is_load & (~r_e_is_mdu | e_ready_i);
      w_m_fwd_ok = ~r_m_is_load | m_ready_i;
      w_rs1_res  = f_resolve(f_hit(d_rs1_used_i, d_rs1_addr_i, r_e_valid, r_e_we, r_e_rd),
                             f_hit(d_rs1_used_i, d_rs1_addr_i, r_m_valid, r_m_we, r_m_rd),
                             w_e_fwd_ok, w_m_fwd_ok);
      w_rs2_res  = f_resolve(f_hit(d_rs2_used_i, d_rs2_addr_i, r_e_valid, r_e_we, r_e_rd),
                             f_hit(d_rs2_used_i, d_rs2_addr_i, r_m_valid, r_m_we, r_m_rd),
                             w_e_fwd_ok, w_m_fwd_ok);
      w_hazard   = w_rs1_res[2] | w_rs2_res[2];
      // A flush releases D so fetch can redirect, even while E is held
      w_d_stall  = d_valid_i & ~flush_i & (w_hazard | w_e_stall);
      w_issue    = d_valid_i & ~flush_i & ~w_d_stall;
   end

   assign rs1_bypass_o = w_rs1_res[1:0];
   assign rs2_bypass_o = w_rs2_res[1:0];
   assign d_stall_o    = w_d_stall;
   assign e_stall_o    = w_e_stall;
   assign m_stall_o    = w_m_stall;
   // Gated by reset so the bubble request is quiet while the core is held in reset
   assign e_bubble_o   = arstn_i & ~w_e_stall & ~w_issue;
   assign stall_cnt_o  = r_stall_cnt;

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         r_e_valid   <= 1'b0;
         r_e_we      <= 1'b0;
         r_e_is_load <= 1'b0;
         r_e_is_mdu  <= 1'b0;
         r_e_rd      <= 5'd0;
         r_m_valid   <= 1'b0;
         r_m_we      <= 1'b0;
         r_m_is_load <= 1'b0;
         r_m_rd      <= 5'd0;
         r_stall_cnt <= '0;
      end else begin
         if (!w_m_stall) begin
            if (r_e_valid && !w_e_stall) begin
               r_m_valid   <= 1'b1;
               r_m_we      <= r_e_we;
               r_m_is_load <= r_e_is_load;
               r_m_rd      <= r_e_rd;
            end else begin
               r_m_valid   <= 1'b0;
            end
         end
         if (!w_e_stall) begin
            if (w_issue) begin
               r_e_valid   <= 1'b1;
               r_e_we      <= d_we_i;
               r_e_is_load <= d_is_load_i;
               r_e_is_mdu  <= d_is_mdu_i;
               r_e_rd      <= d_rd_addr_i;
            end else begin
               r_e_valid   <= 1'b0;
            end
         end
         if (w_d_stall && (r_stall_cnt != {STALL_CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule
